mem_stage: RTL and testbench

- MEM pipeline stage; consumes the EX/MEM register outputs produced by the execute stage.
- Performs load/store through a req/ack data-memory port and stalls the pipeline while the access is outstanding.
- Resolves the branch decision.
- Registers results into an internal MEM/WB register for writeback.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_wb_reg.sv | 59 +++++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and its neighbours in the pipeline.
// Contents: datapath width, MEM-stage FSM state encodings, writeback-source
// select encodings (shared with the writeback mux), and the MEM/WB payload.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned SEL_W = 2;

   // MEM-stage access FSM
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // Writeback source select, decoded by the writeback mux
   typedef enum logic [SEL_W-1:0] {
      WB_SEL_ALU = 2'd0,
      WB_SEL_MEM = 2'd1,
      WB_SEL_PC  = 2'd2,
      WB_SEL_IMM = 2'd3
   } wb_sel_e;

   // MEM/WB pipeline payload (load data is held separately)
   typedef struct packed {
      logic             reg_file_write;
      logic [SEL_W-1:0] select_mux_4;
      logic [RD_W-1:0]  addr_rd;
      logic [XLEN-1:0]  alu;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble clears only the
// writeback enable and leaves the remaining fields holding their last value.
// Load data is captured only when load_done is high.
// Ports:
//   clk, reset (async, active-low)
//   bubble             - insert a bubble instead of the incoming instruction
//   load_done          - capture load_data into mem_data_out
//   *_in               - incoming MEM-stage fields
//   load_data          - data returned by memory
//   *_out, mem_data_out - registered MEM/WB fields
module mem_wb_reg
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             bubble,
   input  logic             load_done,
   input  logic             reg_file_write_in,
   input  logic [SEL_W-1:0] select_mux_4_in,
   input  logic [RD_W-1:0]  addr_rd_in,
   input  logic [XLEN-1:0]  alu_in,
   input  logic [XLEN-1:0]  load_data,
   output logic             reg_file_write_out,
   output logic [SEL_W-1:0] select_mux_4_out,
   output logic [RD_W-1:0]  addr_rd_out,
   output logic [XLEN-1:0]  alu_out,
   output logic [XLEN-1:0]  mem_data_out
);

   mem_wb_t         wb_q;
   logic [XLEN-1:0] mem_data_q;

   // Pipeline register with bubble insertion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_q       <= '0;
         mem_data_q <= '0;
      end else begin
         if (bubble) begin
            wb_q.reg_file_write <= 1'b0;
         end else begin
            wb_q <= '{reg_file_write: reg_file_write_in,
                      select_mux_4:   select_mux_4_in,
                      addr_rd:        addr_rd_in,
                      alu:            alu_in};
         end
         if (load_done) begin
            mem_data_q <= load_data;
         end
      end
   end

   assign reg_file_write_out = wb_q.reg_file_write;
   assign select_mux_4_out   = wb_q.select_mux_4;
   assign addr_rd_out        = wb_q.addr_rd;
   assign alu_out            = wb_q.alu;
   assign mem_data_out       = mem_data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory req/ack port for loads and
// stores, stalls upstream while an access is outstanding, aborts after
// TIMEOUT wait cycles with a sticky bus error, resolves the branch and
// feeds the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: accesses with alu_in[1:0] != 0
// are dropped (no request, no stall, retire as a bubble) and flagged on the
// sticky output misalign_err_out.
// Ports:
//   clk, reset (async, active-low)
//   EX/MEM inputs : mem_re_in, mem_we_in, reg_file_write_in, branch_in,
//                   branch_instruction_in, select_mux_2_in, select_mux_4_in,
//                   addr_rd_in, reg_b_in, alu_in, add_pc_in
//   Data memory   : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ack, dmem_rdata
//   Pipeline ctrl : stall_out, pc_src_out, branch_target_out, bus_err_out
//   MEM/WB        : reg_file_write_out, select_mux_4_out, addr_rd_out,
//                   mem_data_out, alu_out
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_re_in,
   input  logic             mem_we_in,
   input  logic             reg_file_write_in,
   input  logic             branch_in,
   input  logic             branch_instruction_in,
   input  logic [1:0]       select_mux_2_in,
   input  logic [1:0]       select_mux_4_in,
   input  logic [4:0]       addr_rd_in,
   input  logic [XLEN-1:0]  reg_b_in,
   input  logic [XLEN-1:0]  alu_in,
   input  logic [XLEN-1:0]  add_pc_in,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_ack,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             stall_out,
   output logic             pc_src_out,
   output logic [XLEN-1:0]  branch_target_out,
   output logic             bus_err_out,
   output logic             reg_file_write_out,
   output logic [1:0]       select_mux_4_out,
   output logic [4:0]       addr_rd_out,
   output logic [XLEN-1:0]  mem_data_out,
   output logic [XLEN-1:0]  alu_out
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic             misalign_err_out
`endif
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_c;
   logic             access_c;
   logic             misalign_c;
   logic             timeout_hit_c;
   logic             stall_c;
   logic             bubble_c;
   logic             load_done_c;
   logic             bus_err_q;
   logic             unused_sel2_c;

   // Passthrough control has no consumer in this stage
   assign unused_sel2_c = ^select_mux_2_in;

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_err_q;

   assign misalign_c = (mem_re_in | mem_we_in) & (alu_in[1:0] != 2'b00);

   // Sticky misaligned-access flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misalign_err_q <= 1'b0;
      end else if (misalign_c) begin
         misalign_err_q <= 1'b1;
      end
   end

   assign misalign_err_out = misalign_err_q;
`else
   assign misalign_c = 1'b0;
`endif

   assign access_c = (mem_re_in | mem_we_in) & ~misalign_c;

   // Access FSM and wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, request and timeout detection
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_c         = 1'b0;
      timeout_hit_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_c) begin
               req_c = 1'b1;
               if (!dmem_ack) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            req_c = 1'b1;
            if (dmem_ack) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               timeout_hit_c = 1'b1;
               state_d       = ST_IDLE;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign stall_c     = req_c & ~dmem_ack & ~timeout_hit_c;
   assign bubble_c    = stall_c | timeout_hit_c | misalign_c;
   // Both strobes high is treated as a store, so no load data is captured
   assign load_done_c = req_c & dmem_ack & mem_re_in & ~mem_we_in;

   // Sticky bus-error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err_q <= 1'b0;
      end else if (timeout_hit_c) begin
         bus_err_q <= 1'b1;
      end
   end

   // Control outputs are forced low while reset is asserted so an
   // in-flight transfer is abandoned at once
   assign dmem_req          = reset & req_c;
   assign stall_out         = reset & stall_c;
   assign pc_src_out        = reset & branch_in & branch_instruction_in & ~stall_c;
   assign dmem_we           = mem_we_in;
   assign dmem_addr         = alu_in;
   assign dmem_wdata        = reg_b_in;
   assign branch_target_out = add_pc_in;
   assign bus_err_out       = bus_err_q;

   mem_wb_reg u_mem_wb_reg (
      .clk                (clk),
      .reset              (reset),
      .bubble             (bubble_c),
      .load_done          (load_done_c),
      .reg_file_write_in  (reg_file_write_in),
      .select_mux_4_in    (select_mux_4_in),
      .addr_rd_in         (addr_rd_in),
      .alu_in             (alu_in),
      .load_data          (dmem_rdata),
      .reg_file_write_out (reg_file_write_out),
      .select_mux_4_out   (select_mux_4_out),
      .addr_rd_out        (addr_rd_out),
      .alu_out            (alu_out),
      .mem_data_out       (mem_data_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset state, a table of single-cycle
// vectors, hand sequences for wait-state store, timeout abort and reset
// mid-access, then randomized traffic against a cycle-level reference model.
module tb_mem_stage;

   localparam int unsigned TO = 16;

   logic        clk;
   logic        reset;
   logic        mem_re_in, mem_we_in, reg_file_write_in;
   logic        branch_in, branch_instruction_in;
   logic [1:0]  select_mux_2_in, select_mux_4_in;
   logic [4:0]  addr_rd_in;
   logic [31:0] reg_b_in, alu_in, add_pc_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall_out, pc_src_out, bus_err_out;
   logic [31:0] branch_target_out;
   logic        reg_file_write_out;
   logic [1:0]  select_mux_4_out;
   logic [4:0]  addr_rd_out;
   logic [31:0] mem_data_out, alu_out;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign_err_out;
`endif

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .mem_re_in             (mem_re_in),
      .mem_we_in             (mem_we_in),
      .reg_file_write_in     (reg_file_write_in),
      .branch_in             (branch_in),
      .branch_instruction_in (branch_instruction_in),
      .select_mux_2_in       (select_mux_2_in),
      .select_mux_4_in       (select_mux_4_in),
      .addr_rd_in            (addr_rd_in),
      .reg_b_in              (reg_b_in),
      .alu_in                (alu_in),
      .add_pc_in             (add_pc_in),
      .dmem_req              (dmem_req),
      .dmem_we               (dmem_we),
      .dmem_addr             (dmem_addr),
      .dmem_wdata            (dmem_wdata),
      .dmem_ack              (dmem_ack),
      .dmem_rdata            (dmem_rdata),
      .stall_out             (stall_out),
      .pc_src_out            (pc_src_out),
      .branch_target_out     (branch_target_out),
      .bus_err_out           (bus_err_out),
      .reg_file_write_out    (reg_file_write_out),
      .select_mux_4_out      (select_mux_4_out),
      .addr_rd_out           (addr_rd_out),
      .mem_data_out          (mem_data_out),
      .alu_out               (alu_out)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .misalign_err_out      (misalign_err_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic re, input logic we, input logic rfw,
                        input logic br, input logic bri, input logic [1:0] sel4,
                        input logic [4:0] rd, input logic [31:0] regb,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic ack, input logic [31:0] rdata);
      mem_re_in             = re;
      mem_we_in             = we;
      reg_file_write_in     = rfw;
      branch_in             = br;
      branch_instruction_in = bri;
      select_mux_2_in       = 2'($urandom);
      select_mux_4_in       = sel4;
      addr_rd_in            = rd;
      reg_b_in              = regb;
      alu_in                = alu;
      add_pc_in             = pc;
      dmem_ack              = ack;
      dmem_rdata            = rdata;
   endtask

   task automatic nop(input logic ack);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, ack, 32'h0);
   endtask

   typedef struct {
      logic        re, we, rfw, br, bri, ack;
      logic [1:0]  sel4;
      logic [4:0]  rd;
      logic [31:0] regb, alu, pc, rdata;
      logic        exp_req, exp_stall, exp_pc, exp_rfw;
      logic [31:0] exp_mdata;
   } vec_t;

   vec_t tv[8];

   // Random-phase model state and stimulus
   int          waited, lat;
   logic        prev_stall;
   logic        m_bus, m_rfw;
   logic [1:0]  m_sel;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_md;
   logic        r_re, r_we, r_rfw, r_br, r_bri, r_ack;
   logic [1:0]  r_sel;
   logic [4:0]  r_rd;
   logic [31:0] r_regb, r_alu, r_pc, r_rdata;
   logic        e_req, e_stall, e_abort;
   int          nst;

   initial begin
      tv[0] = '{re:0, we:0, rfw:1, br:0, bri:0, ack:0, sel4:2'd0, rd:5'd5,  regb:32'h0,  alu:32'h1111,
                pc:32'h4,  rdata:32'h0,        exp_req:0, exp_stall:0, exp_pc:0, exp_rfw:1, exp_mdata:32'h0};
      tv[1] = '{re:1, we:0, rfw:1, br:0, bri:0, ack:1, sel4:2'd1, rd:5'd7,  regb:32'h0,  alu:32'h100,
                pc:32'h8,  rdata:32'hDEADBEEF, exp_req:1, exp_stall:0, exp_pc:0, exp_rfw:1, exp_mdata:32'hDEADBEEF};
      tv[2] = '{re:0, we:0, rfw:0, br:1, bri:1, ack:0, sel4:2'd2, rd:5'd0,  regb:32'h0,  alu:32'h3,
                pc:32'h80, rdata:32'h0,        exp_req:0, exp_stall:0, exp_pc:1, exp_rfw:0, exp_mdata:32'hDEADBEEF};
      tv[3] = '{re:0, we:0, rfw:0, br:0, bri:1, ack:0, sel4:2'd0, rd:5'd0,  regb:32'h0,  alu:32'h0,
                pc:32'h80, rdata:32'h0,        exp_req:0, exp_stall:0, exp_pc:0, exp_rfw:0, exp_mdata:32'hDEADBEEF};
      tv[4] = '{re:0, we:0, rfw:1, br:1, bri:0, ack:0, sel4:2'd3, rd:5'd2,  regb:32'h0,  alu:32'h10,
                pc:32'h90, rdata:32'h0,        exp_req:0, exp_stall:0, exp_pc:0, exp_rfw:1, exp_mdata:32'hDEADBEEF};
      tv[5] = '{re:1, we:1, rfw:0, br:0, bri:0, ack:1, sel4:2'd0, rd:5'd1,  regb:32'h77, alu:32'h44,
                pc:32'h0,  rdata:32'hCAFEF00D, exp_req:1, exp_stall:0, exp_pc:0, exp_rfw:0, exp_mdata:32'hDEADBEEF};
      tv[6] = '{re:0, we:0, rfw:1, br:0, bri:0, ack:1, sel4:2'd0, rd:5'd9,  regb:32'h0,  alu:32'h2222,
                pc:32'h0,  rdata:32'h55555555, exp_req:0, exp_stall:0, exp_pc:0, exp_rfw:1, exp_mdata:32'hDEADBEEF};
      tv[7] = '{re:1, we:0, rfw:1, br:1, bri:1, ack:1, sel4:2'd1, rd:5'd31, regb:32'h0,  alu:32'h104,
                pc:32'hC0, rdata:32'h0BADF00D, exp_req:1, exp_stall:0, exp_pc:1, exp_rfw:1, exp_mdata:32'h0BADF00D};

      // Reset state
      reset = 1'b0;
      nop(1'b0);
      @(negedge clk);
      chk1 ("rst_req",   dmem_req, 1'b0);
      chk1 ("rst_stall", stall_out, 1'b0);
      chk1 ("rst_rfw",   reg_file_write_out, 1'b0);
      chk32("rst_alu",   alu_out, 32'h0);
      chk32("rst_mdata", mem_data_out, 32'h0);
      chk1 ("rst_buserr", bus_err_out, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Single-cycle vectors
      for (int i = 0; i < 8; i++) begin
         drive(tv[i].re, tv[i].we, tv[i].rfw, tv[i].br, tv[i].bri, tv[i].sel4, tv[i].rd,
               tv[i].regb, tv[i].alu, tv[i].pc, tv[i].ack, tv[i].rdata);
         #1;
         chk1 ($sformatf("v%0d_req", i),    dmem_req,   tv[i].exp_req);
         chk1 ($sformatf("v%0d_stall", i),  stall_out,  tv[i].exp_stall);
         chk1 ($sformatf("v%0d_pcsrc", i),  pc_src_out, tv[i].exp_pc);
         chk32($sformatf("v%0d_target", i), branch_target_out, tv[i].pc);
         chk1 ($sformatf("v%0d_we", i),     dmem_we,    tv[i].we);
         @(negedge clk);
         chk1 ($sformatf("v%0d_rfw", i),    reg_file_write_out, tv[i].exp_rfw);
         chk32($sformatf("v%0d_rd", i),     32'(addr_rd_out), 32'(tv[i].rd));
         chk32($sformatf("v%0d_sel4", i),   32'(select_mux_4_out), 32'(tv[i].sel4));
         chk32($sformatf("v%0d_alu", i),    alu_out, tv[i].alu);
         chk32($sformatf("v%0d_mdata", i),  mem_data_out, tv[i].exp_mdata);
      end

      // Store acknowledged after three wait cycles
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd3, 32'h0, 32'h999, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk32("pre_store_alu", alu_out, 32'h999);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd4, 32'h1234, 32'h40, 32'h0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1 ($sformatf("st_w%0d_req", k),   dmem_req, 1'b1);
         chk1 ($sformatf("st_w%0d_we", k),    dmem_we, 1'b1);
         chk32($sformatf("st_w%0d_wdata", k), dmem_wdata, 32'h1234);
         chk32($sformatf("st_w%0d_addr", k),  dmem_addr, 32'h40);
         chk1 ($sformatf("st_w%0d_stall", k), stall_out, 1'b1);
         @(negedge clk);
         chk1 ($sformatf("st_b%0d_rfw", k),   reg_file_write_out, 1'b0);
         chk32($sformatf("st_b%0d_alu", k),   alu_out, 32'h999);
      end
      dmem_ack = 1'b1;
      #1;
      chk1("st_ack_req",   dmem_req, 1'b1);
      chk1("st_ack_stall", stall_out, 1'b0);
      @(negedge clk);
      chk32("st_ret_alu", alu_out, 32'h40);
      chk32("st_ret_rd",  32'(addr_rd_out), 32'd4);

      // Load that is never acknowledged: timeout abort
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd6, 32'h0, 32'h200, 32'h0, 1'b0, 32'h0);
      nst = 0;
      #1;
      while (stall_out === 1'b1 && nst < 40) begin
         nst++;
         @(negedge clk);
         #1;
      end
      chk32("to_stall_cycles", 32'(nst), 32'(TO));
      chk1 ("to_abort_req",   dmem_req, 1'b1);
      chk1 ("to_abort_stall", stall_out, 1'b0);
      @(negedge clk);
      chk1("to_rfw",    reg_file_write_out, 1'b0);
      chk1("to_buserr", bus_err_out, 1'b1);
      nop(1'b0);
      #1;
      chk1("to_req_drop", dmem_req, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk1("to_buserr_sticky", bus_err_out, 1'b1);

      // Reset while waiting on a load
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd8, 32'h0, 32'h300, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk1 ("rw_req",    dmem_req, 1'b0);
      chk1 ("rw_stall",  stall_out, 1'b0);
      chk1 ("rw_pcsrc",  pc_src_out, 1'b0);
      chk1 ("rw_rfw",    reg_file_write_out, 1'b0);
      chk32("rw_rd",     32'(addr_rd_out), 32'd0);
      chk32("rw_alu",    alu_out, 32'h0);
      chk32("rw_mdata",  mem_data_out, 32'h0);
      chk1 ("rw_buserr", bus_err_out, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      nop(1'b1);
      dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk1("late_ack_req", dmem_req, 1'b0);
      @(negedge clk);
      chk32("late_ack_mdata", mem_data_out, 32'h0);
      chk1 ("late_ack_rfw",   reg_file_write_out, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd10, 32'h0, 32'h400, 32'h0, 1'b1, 32'h13579BDF);
      #1;
      chk1("post_rst_req",   dmem_req, 1'b1);
      chk1("post_rst_stall", stall_out, 1'b0);
      @(negedge clk);
      chk32("post_rst_mdata", mem_data_out, 32'h13579BDF);
      chk32("post_rst_rd",    32'(addr_rd_out), 32'd10);
      chk1 ("post_rst_rfw",   reg_file_write_out, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned load is dropped
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd11, 32'h0, 32'h102, 32'h0, 1'b0, 32'h0);
      #1;
      chk1("mis_req",   dmem_req, 1'b0);
      chk1("mis_stall", stall_out, 1'b0);
      @(negedge clk);
      chk1("mis_rfw", reg_file_write_out, 1'b0);
      chk1("mis_err", misalign_err_out, 1'b1);
`endif

      // Randomized traffic against the reference model
      reset = 1'b0;
      nop(1'b0);
      @(negedge clk);
      reset = 1'b1;
      waited = 0; lat = 0; prev_stall = 1'b0;
      m_bus = 1'b0; m_rfw = 1'b0; m_sel = 2'd0; m_rd = 5'd0; m_alu = 32'h0; m_md = 32'h0;
      r_re = 1'b0; r_we = 1'b0; r_rfw = 1'b0; r_br = 1'b0; r_bri = 1'b0;
      r_sel = 2'd0; r_rd = 5'd0; r_regb = 32'h0; r_alu = 32'h0; r_pc = 32'h0;
      for (int c = 0; c < 400; c++) begin
         if (!prev_stall) begin
            case ($urandom_range(0, 5))
               0, 1:    begin r_re = 1'b1; r_we = 1'b0; end
               2:       begin r_re = 1'b0; r_we = 1'b1; end
               3:       begin r_re = 1'b1; r_we = 1'b1; end
               default: begin r_re = 1'b0; r_we = 1'b0; end
            endcase
            r_rfw  = 1'($urandom);
            r_br   = 1'($urandom);
            r_bri  = 1'($urandom);
            r_sel  = 2'($urandom);
            r_rd   = 5'($urandom);
            r_regb = $urandom;
            r_alu  = $urandom & 32'hFFFF_FFFC;
            r_pc   = $urandom;
            lat    = $urandom_range(0, 20);
         end
         r_rdata = $urandom;
         // Memory answers 'lat' cycles into an access; stray acks otherwise
         e_req   = (waited > 0) || r_re || r_we;
         r_ack   = e_req ? (waited == lat) : ($urandom_range(0, 3) == 0);
         e_abort = e_req && !r_ack && (waited == int'(TO));
         e_stall = e_req && !r_ack && !e_abort;
         drive(r_re, r_we, r_rfw, r_br, r_bri, r_sel, r_rd, r_regb, r_alu, r_pc, r_ack, r_rdata);
         #1;
         chk1 ($sformatf("rnd%0d_req", c),   dmem_req,   e_req);
         chk1 ($sformatf("rnd%0d_stall", c), stall_out,  e_stall);
         chk1 ($sformatf("rnd%0d_pcsrc", c), pc_src_out, r_br & r_bri & ~e_stall);
         chk1 ($sformatf("rnd%0d_we", c),    dmem_we,    r_we);
         chk32($sformatf("rnd%0d_addr", c),  dmem_addr,  r_alu);
         if (e_stall) waited++;
         else waited = 0;
         if (e_stall || e_abort) begin
            m_rfw = 1'b0;
         end else begin
            m_rfw = r_rfw; m_sel = r_sel; m_rd = r_rd; m_alu = r_alu;
         end
         if (e_req && r_ack && r_re && !r_we) m_md = r_rdata;
         if (e_abort) m_bus = 1'b1;
         prev_stall = e_stall;
         @(negedge clk);
         chk1 ($sformatf("rnd%0d_rfw", c),    reg_file_write_out, m_rfw);
         chk32($sformatf("rnd%0d_sel4", c),   32'(select_mux_4_out), 32'(m_sel));
         chk32($sformatf("rnd%0d_rd", c),     32'(addr_rd_out), 32'(m_rd));
         chk32($sformatf("rnd%0d_alu", c),    alu_out, m_alu);
         chk32($sformatf("rnd%0d_mdata", c),  mem_data_out, m_md);
         chk1 ($sformatf("rnd%0d_buserr", c), bus_err_out, m_bus);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
